// File: rtl/shift_sub_divider_pkg.sv
// Shared definitions for the shift-add multiplier / shift-subtract divider pair:
// FSM state encoding and the default operand width.
package shift_sub_divider_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int DEFAULT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } state_t;

endpackage

// File: rtl/shift_sub_divider_step.sv
// One combinational restoring-division step: shift {R,Qr} left by one, then
// subtract the divisor when the shifted partial remainder is not smaller.
module shift_sub_divider_step #(
    parameter int W = 16
) (
    input  logic [W-1:0] i_r,
    input  logic [W-1:0] i_qr,
    input  logic [W-1:0] i_divisor,
    output logic [W-1:0] o_r,
    output logic [W-1:0] o_qr
);

    logic [W:0] w_t;
    logic       w_ge;

    // The shifted remainder needs W+1 bits; the kept result is always < divisor.
    assign w_t  = {i_r, i_qr[W-1]};
    assign w_ge = (w_t >= {1'b0, i_divisor});
    assign o_r  = w_ge ? (w_t[W-1:0] - i_divisor) : w_t[W-1:0];
    assign o_qr = {i_qr[W-2:0], w_ge};

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, one quotient
// bit per clock, launched on the rising edge of a level-held start.
module shift_sub_divider
    import shift_sub_divider_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int CNT_W = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           busy,
    output logic           done,
    output logic           div_zero,
    output logic           overflow
);

    state_t           r_state;
    logic             r_start_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;
    logic             r_overflow;
    logic [W-1:0]     r_quotient;
    logic [W-1:0]     r_remainder;

    logic [W-1:0]     r_r;
    logic [W-1:0]     r_qr;
    logic [W-1:0]     r_divisor;

    logic             w_launch;
    logic             w_zero;
    logic             w_ovf;
    logic [W-1:0]     w_r_next;
    logic [W-1:0]     w_qr_next;

    assign w_launch = start & ~r_start_q & (r_state == ST_IDLE);
    assign w_zero   = (divisor == '0);
    assign w_ovf    = (dividend[2*W-1:W] >= divisor);

    shift_sub_divider_step #(.W(W)) u_step (
        .i_r       (r_r),
        .i_qr      (r_qr),
        .i_divisor (r_divisor),
        .o_r       (w_r_next),
        .o_qr      (w_qr_next)
    );

    // Control path and visible results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_start_q   <= 1'b0;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_div_zero  <= 1'b0;
            r_overflow  <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            r_start_q <= start;
            r_done    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_cnt      <= '0;
                        r_div_zero <= w_zero;
                        r_overflow <= ~w_zero & w_ovf;
                        if (w_zero || w_ovf) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(W - 1)) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_done      <= 1'b1;
                    r_quotient  <= r_qr;
                    r_remainder <= r_r;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Datapath; error launches preload the saturated quotient so DONE can copy it out
    always_ff @(posedge clk) begin
        if (w_launch) begin
            r_divisor <= divisor;
            if (w_zero || w_ovf) begin
                r_r  <= dividend[W-1:0];
                r_qr <= '1;
            end else begin
                r_r  <= dividend[2*W-1:W];
                r_qr <= dividend[W-1:0];
            end
        end else if (r_state == ST_RUN) begin
            r_r  <= w_r_next;
            r_qr <= w_qr_next;
        end
    end

    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign busy      = r_busy;
    assign done      = r_done;
    assign div_zero  = r_div_zero;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed-vector bench for the sequential shift-subtract divider.
module tb_shift_sub_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    shift_sub_divider #(.W(16), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Returns 1 ns after the launch edge, with start left high.
    task automatic launch(input logic [31:0] dd, input logic [15:0] dv);
        start    = 1'b0;
        dividend = dd;
        divisor  = dv;
        @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Counts clock edges after the launch edge until done is seen; -1 on timeout.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++; if (quotient !== 16'h0)  begin n_errors++; $display("FAIL reset_quotient: got %h want %h", quotient, 16'h0); end
        n_checks++; if (remainder !== 16'h0) begin n_errors++; $display("FAIL reset_remainder: got %h want %h", remainder, 16'h0); end
        n_checks++; if ({busy, done, div_zero, overflow} !== 4'b0) begin n_errors++; $display("FAIL reset_flags: got %b want 0000", {busy, done, div_zero, overflow}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        launch(32'h0000_0064, 16'h0007);
        n_checks++; if ({busy, done} !== 2'b10) begin n_errors++; $display("FAIL t1_busy_after_launch: got %b want 10", {busy, done}); end
        wait_done(lat);
        n_checks++; if (lat !== 17)              begin n_errors++; $display("FAIL t1_latency: got %0d want 17", lat); end
        n_checks++; if (quotient !== 16'h000E)   begin n_errors++; $display("FAIL t1_quotient: got %h want %h", quotient, 16'h000E); end
        n_checks++; if (remainder !== 16'h0002)  begin n_errors++; $display("FAIL t1_remainder: got %h want %h", remainder, 16'h0002); end
        n_checks++; if ({busy, div_zero, overflow} !== 3'b0) begin n_errors++; $display("FAIL t1_flags: got %b want 000", {busy, div_zero, overflow}); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0)           begin n_errors++; $display("FAIL t1_done_one_cycle: got %b want 0", done); end
        n_checks++; if (quotient !== 16'h000E)   begin n_errors++; $display("FAIL t1_quotient_hold: got %h want %h", quotient, 16'h000E); end

        launch(32'h0001_44CE, 16'h067F);
        wait_done(lat);
        n_checks++; if (lat !== 17)              begin n_errors++; $display("FAIL t2_latency: got %0d want 17", lat); end
        n_checks++; if (quotient !== 16'h0032)   begin n_errors++; $display("FAIL t2_quotient: got %h want %h", quotient, 16'h0032); end
        n_checks++; if (remainder !== 16'h0000)  begin n_errors++; $display("FAIL t2_remainder: got %h want %h", remainder, 16'h0000); end

        // Largest in-range quotient: 0xFFFF * 0xFFFF = 0xFFFE0001
        launch(32'hFFFE_0001, 16'hFFFF);
        wait_done(lat);
        n_checks++; if (quotient !== 16'hFFFF)   begin n_errors++; $display("FAIL tmax_quotient: got %h want %h", quotient, 16'hFFFF); end
        n_checks++; if (remainder !== 16'h0000)  begin n_errors++; $display("FAIL tmax_remainder: got %h want %h", remainder, 16'h0000); end

        launch(32'h0000_0005, 16'h0009);
        wait_done(lat);
        n_checks++; if (quotient !== 16'h0000)   begin n_errors++; $display("FAIL tsmall_quotient: got %h want %h", quotient, 16'h0000); end
        n_checks++; if (remainder !== 16'h0005)  begin n_errors++; $display("FAIL tsmall_remainder: got %h want %h", remainder, 16'h0005); end
    endtask

    task automatic test_div_zero();
        int lat;
        launch(32'h1234_5678, 16'h0000);
        wait_done(lat);
        n_checks++; if (lat !== 1)               begin n_errors++; $display("FAIL t3_latency: got %0d want 1", lat); end
        n_checks++; if (div_zero !== 1'b1)       begin n_errors++; $display("FAIL t3_div_zero: got %b want 1", div_zero); end
        n_checks++; if (overflow !== 1'b0)       begin n_errors++; $display("FAIL t3_overflow: got %b want 0", overflow); end
        n_checks++; if (quotient !== 16'hFFFF)   begin n_errors++; $display("FAIL t3_quotient: got %h want %h", quotient, 16'hFFFF); end
        n_checks++; if (remainder !== 16'h5678)  begin n_errors++; $display("FAIL t3_remainder: got %h want %h", remainder, 16'h5678); end
        n_checks++; if (busy !== 1'b0)           begin n_errors++; $display("FAIL t3_busy: got %b want 0", busy); end
        repeat (3) @(posedge clk); #1;
        n_checks++; if (div_zero !== 1'b1)       begin n_errors++; $display("FAIL t3_div_zero_sticky: got %b want 1", div_zero); end
    endtask

    task automatic test_overflow();
        int lat;
        launch(32'h0001_0000, 16'h0001);
        wait_done(lat);
        n_checks++; if (lat !== 1)               begin n_errors++; $display("FAIL t4_latency: got %0d want 1", lat); end
        n_checks++; if (overflow !== 1'b1)       begin n_errors++; $display("FAIL t4_overflow: got %b want 1", overflow); end
        n_checks++; if (div_zero !== 1'b0)       begin n_errors++; $display("FAIL t4_div_zero_cleared: got %b want 0", div_zero); end
        n_checks++; if (quotient !== 16'hFFFF)   begin n_errors++; $display("FAIL t4_quotient: got %h want %h", quotient, 16'hFFFF); end
        n_checks++; if (remainder !== 16'h0000)  begin n_errors++; $display("FAIL t4_remainder: got %h want %h", remainder, 16'h0000); end

        launch(32'h0000_FFFF, 16'h0001);
        n_checks++; if (overflow !== 1'b0)       begin n_errors++; $display("FAIL t4b_overflow_cleared: got %b want 0", overflow); end
        wait_done(lat);
        n_checks++; if (lat !== 17)              begin n_errors++; $display("FAIL t4b_latency: got %0d want 17", lat); end
        n_checks++; if (quotient !== 16'hFFFF)   begin n_errors++; $display("FAIL t4b_quotient: got %h want %h", quotient, 16'hFFFF); end
        n_checks++; if (remainder !== 16'h0000)  begin n_errors++; $display("FAIL t4b_remainder: got %h want %h", remainder, 16'h0000); end
    endtask

    task automatic test_start_hold();
        int pulses = 0;
        launch(32'h0000_0064, 16'h0007);
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
            if ((done === 1'b1) && (busy === 1'b1)) pulses += 100;
        end
        n_checks++; if (pulses !== 1)            begin n_errors++; $display("FAIL t5_hold_pulses: got %0d want 1", pulses); end
        n_checks++; if (quotient !== 16'h000E)   begin n_errors++; $display("FAIL t5_hold_quotient: got %h want %h", quotient, 16'h000E); end
    endtask

    task automatic test_back_to_back();
        int lat = -1;
        int pulses = 0;
        launch(32'h0001_44CE, 16'h067F);
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                pulses++;
                if (lat < 0) lat = i;
            end
            if (i == 3) begin
                start    = 1'b0;
                dividend = 32'h0000_0064;
                divisor  = 16'h0007;
            end
            if (i == 5) start = 1'b1;
        end
        n_checks++; if (lat !== 17)              begin n_errors++; $display("FAIL t5_repulse_latency: got %0d want 17", lat); end
        n_checks++; if (pulses !== 1)            begin n_errors++; $display("FAIL t5_repulse_pulses: got %0d want 1", pulses); end
        n_checks++; if (quotient !== 16'h0032)   begin n_errors++; $display("FAIL t5_repulse_quotient: got %h want %h", quotient, 16'h0032); end
        n_checks++; if (remainder !== 16'h0000)  begin n_errors++; $display("FAIL t5_repulse_remainder: got %h want %h", remainder, 16'h0000); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int pulses = 0;
        launch(32'h0000_0064, 16'h0007);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (quotient !== 16'h0)      begin n_errors++; $display("FAIL t6_quotient: got %h want %h", quotient, 16'h0); end
        n_checks++; if (remainder !== 16'h0)     begin n_errors++; $display("FAIL t6_remainder: got %h want %h", remainder, 16'h0); end
        n_checks++; if ({busy, done, div_zero, overflow} !== 4'b0) begin n_errors++; $display("FAIL t6_flags: got %b want 0000", {busy, done, div_zero, overflow}); end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) pulses++;
        end
        n_checks++; if (pulses !== 0)            begin n_errors++; $display("FAIL t6_no_done: got %0d want 0", pulses); end
        @(negedge clk);
        rst_n = 1'b1;
        launch(32'h0000_0064, 16'h0007);
        wait_done(lat);
        n_checks++; if (lat !== 17)              begin n_errors++; $display("FAIL t6_relaunch_latency: got %0d want 17", lat); end
        n_checks++; if (quotient !== 16'h000E)   begin n_errors++; $display("FAIL t6_relaunch_quotient: got %h want %h", quotient, 16'h000E); end
        n_checks++; if (remainder !== 16'h0002)  begin n_errors++; $display("FAIL t6_relaunch_remainder: got %h want %h", remainder, 16'h0002); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_overflow();
        test_start_hold();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
